dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage of the RV32I pipeline.
- Inputs are the memory_type / memory_rw control fields produced by decode, plus the ALU-computed address and rs2 store data.
- Drives a req/gnt/rvalid data-memory bus: byte-enable generation, store-lane replication, load extraction with sign/zero extension.
- Stalls the pipeline until the access completes; reports misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 64, cycles allowed in REQ+WAIT before a bus error is declared (range 2..255).
- CNT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- mem_valid  in  1  MEM-stage instruction valid (not a bubble)
- memory_type  in  4  MT_B / MT_H / MT_W / MT_BU / MT_HU / MT_X (consts.v encoding)
- memory_rw  in  2  M_R / M_W / M_X
- addr  in  32  byte address from the ALU
- store_data  in  32  rs2 value
- mem_stall  out  1  hold the pipeline (combinational)
- load_data  out  32  extended load result, valid while resp_valid=1
- resp_valid  out  1  one-cycle completion pulse
- misalign  out  1  one-cycle misaligned-access pulse
- bus_err  out  1  one-cycle timeout pulse
- fault_addr  out  32  address of the faulting access, held until the next fault
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE, counter=0; every registered output=0, including load_data and fault_addr.
  - Comb outputs are then 0: mem_stall=0 in IDLE with no start, dmem_req=0.
  - Reset mid-access abandons the access. dmem_req drops at that edge; a late dmem_rvalid in IDLE is ignored.
- start = mem_valid & (memory_rw==M_R | memory_rw==M_W) & memory_type!=MT_X. Any other combination is a no-op: no stall, no bus activity.
- Misalignment: H/HU with addr[0]=1; W with addr[1:0]!=0. B/BU are never misaligned.
- FSM states: IDLE, REQ, WAIT, DONE, ERR.
  - IDLE: on start, mem_stall=1.
    - Aligned: latch addr/type/rw/store_data, counter=0, go to REQ.
    - Misaligned: latch fault_addr=addr, go to ERR.
  - REQ: dmem_req=1; dmem_we/addr/be/wdata stay stable until gnt; mem_stall=1.
    - On gnt with a write: go to DONE.
    - On gnt with a read: go to WAIT.
    - dmem_rvalid is ignored in REQ.
  - WAIT: mem_stall=1, dmem_req=0. On rvalid: register the extracted load_data, go to DONE.
  - DONE: resp_valid=1, mem_stall=0 (pipeline advances this edge); next state IDLE. start is not sampled in DONE.
  - ERR: misalign=1 or bus_err=1 (whichever fault caused entry), mem_stall=0; next state IDLE.
- Timeout: counter increments each cycle in REQ/WAIT. Reaching TIMEOUT-1 without gnt/rvalid latches fault_addr, goes to ERR with bus_err. gnt/rvalid in that same cycle wins over timeout.
- Minimum latency (start cycle to resp_valid):
  - Write: 2 cycles (gnt in the first REQ cycle).
  - Read: 3 cycles (rvalid in the cycle after gnt).
- Byte enables, where o = addr[1:0]:
  - B: 4'b0001<<o
  - H: 4'b0011<<o
  - W: 4'b1111
- Store data:
  - B: {4{sd[7:0]}}
  - H: {2{sd[15:0]}}
  - W: sd
  - On loads, dmem_be is still driven as above and dmem_wdata=0.
- Load extraction:
  - Byte = rdata[8*o+7 : 8*o]; halfword = rdata[16*o[1]+15 : 16*o[1]].
  - B/H sign-extend; BU/HU zero-extend; W passes rdata through.

Test Plan:
- LW addr=0x100; gnt in 1st REQ cycle, rvalid next cycle, rdata=0xDEADBEEF:
  - Expect dmem_addr=0x100, be=1111, we=0.
  - Expect mem_stall high for 3 cycles, then resp_valid with load_data=0xDEADBEEF.
- LB addr=0x203, rdata=0x80FF1234 -> load_data=0xFFFFFF80. LBU, same inputs -> 0x00000080. LHU addr=0x202 -> 0x000080FF.
- SB addr=0x301, sd=0x000000A5, gnt delayed 3 cycles:
  - Expect be=0010 and wdata=0xA5A5A5A5, stable while waiting.
  - Expect resp_valid 1 cycle after gnt.
- LH addr=0x401 -> no dmem_req; misalign pulse 1 cycle; fault_addr=0x401; mem_stall high exactly 1 cycle.
- SW addr=0x500, gnt never asserted, TIMEOUT=4 -> bus_err pulse after 4 REQ cycles, fault_addr=0x500, then IDLE.
- Read granted, reset_n=0 in WAIT, rvalid arrives after reset -> outputs all 0, resp_valid never asserted. memory_rw=M_X with mem_valid=1 -> no stall.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the MEM stage: byte enables, store lane replication, load extension.
// Latency: store 2 cycles, load 3 cycles minimum from start to resp_valid; misaligned access faults in 1.
// Backpressure: mem_stall holds the pipeline while the bus request waits for gnt and the load waits for rvalid.
module dmem_access_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    input  logic [3:0]  memory_type,
    input  logic [1:0]  memory_rw,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        resp_valid,
    output logic        misalign,
    output logic        bus_err,
    output logic [31:0] fault_addr,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam logic [3:0] MT_X  = 4'd0;
    localparam logic [3:0] MT_B  = 4'd1;
    localparam logic [3:0] MT_H  = 4'd2;
    localparam logic [3:0] MT_BU = 4'd5;
    localparam logic [3:0] MT_HU = 4'd6;
    localparam logic [1:0] M_R   = 2'd1;
    localparam logic [1:0] M_W   = 2'd2;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr;
    logic [31:0]      r_sd;
    logic [3:0]       r_type;
    logic             r_we;
    logic             r_is_bus_err;
    logic [31:0]      r_load_data;
    logic [31:0]      r_fault_addr;

    logic             w_start;
    logic             w_misaligned;
    logic             w_timeout;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_load_ext;
    logic             w_in_req;

    // Byte/halfword accesses use the sub-word offset; anything else is treated as a full word.
    function automatic logic is_byte(input logic [3:0] t);
        return (t == MT_B) || (t == MT_BU);
    endfunction

    function automatic logic is_half(input logic [3:0] t);
        return (t == MT_H) || (t == MT_HU);
    endfunction

    function automatic logic [31:0] extract(input logic [3:0] t, input logic [1:0] o,
                                             input logic [31:0] d);
        logic [31:0] sh_b;
        logic [31:0] sh_h;
        logic [31:0] res;
        sh_b = d >> {o, 3'b000};
        sh_h = d >> {o[1], 4'b0000};
        case (t)
            MT_B:    res = {{24{sh_b[7]}}, sh_b[7:0]};
            MT_BU:   res = {24'd0, sh_b[7:0]};
            MT_H:    res = {{16{sh_h[15]}}, sh_h[15:0]};
            MT_HU:   res = {16'd0, sh_h[15:0]};
            default: res = d;
        endcase
        return res;
    endfunction

    assign w_start = mem_valid && ((memory_rw == M_R) || (memory_rw == M_W)) && (memory_type != MT_X);

    assign w_misaligned = is_byte(memory_type) ? 1'b0 :
                          is_half(memory_type) ? addr[0] :
                                                 (addr[1:0] != 2'b00);

    // The bus window covers REQ and WAIT together, so the counter is not cleared on gnt.
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    assign w_be = is_byte(r_type) ? (4'b0001 << r_addr[1:0]) :
                  is_half(r_type) ? (4'b0011 << r_addr[1:0]) :
                                    4'b1111;

    assign w_wdata = is_byte(r_type) ? {4{r_sd[7:0]}} :
                     is_half(r_type) ? {2{r_sd[15:0]}} :
                                       r_sd;

    assign w_load_ext = extract(r_type, r_addr[1:0], dmem_rdata);
    assign w_in_req   = (r_state == S_REQ);

    // Access sequencing, timeout counting and result/fault capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_sd         <= '0;
            r_type       <= MT_X;
            r_we         <= 1'b0;
            r_is_bus_err <= 1'b0;
            r_load_data  <= '0;
            r_fault_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        if (w_misaligned) begin
                            r_fault_addr <= addr;
                            r_is_bus_err <= 1'b0;
                            r_state      <= S_ERR;
                        end else begin
                            r_addr  <= addr;
                            r_sd    <= store_data;
                            r_type  <= memory_type;
                            r_we    <= (memory_rw == M_W);
                            r_cnt   <= '0;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (dmem_gnt) begin
                        r_state <= r_we ? S_DONE : S_WAIT;
                    end else if (w_timeout) begin
                        r_fault_addr <= r_addr;
                        r_is_bus_err <= 1'b1;
                        r_state      <= S_ERR;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (dmem_rvalid) begin
                        r_load_data <= w_load_ext;
                        r_state     <= S_DONE;
                    end else if (w_timeout) begin
                        r_fault_addr <= r_addr;
                        r_is_bus_err <= 1'b1;
                        r_state      <= S_ERR;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The stall is raised in the start cycle itself so the pipeline never advances past an issuing access.
    assign mem_stall  = ((r_state == S_IDLE) && w_start) || (r_state == S_REQ) || (r_state == S_WAIT);
    assign resp_valid = (r_state == S_DONE);
    assign misalign   = (r_state == S_ERR) && !r_is_bus_err;
    assign bus_err    = (r_state == S_ERR) && r_is_bus_err;
    assign load_data  = r_load_data;
    assign fault_addr = r_fault_addr;

    // Bus fields are zero outside REQ; wdata is zero for loads.
    assign dmem_req   = w_in_req;
    assign dmem_we    = w_in_req && r_we;
    assign dmem_addr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign dmem_be    = w_in_req ? w_be : 4'd0;
    assign dmem_wdata = (w_in_req && r_we) ? w_wdata : 32'd0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

    localparam int TO = 4;
    localparam logic [3:0] MT_X = 4'd0, MT_B = 4'd1, MT_H = 4'd2, MT_W = 4'd3, MT_BU = 4'd5, MT_HU = 4'd6;
    localparam logic [1:0] M_X = 2'd0, M_R = 2'd1, M_W = 2'd2;
    localparam int K_RESP = 0, K_MIS = 1, K_BUS = 2;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid;
    logic [3:0]  memory_type;
    logic [1:0]  memory_rw;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_stall;
    logic [31:0] load_data;
    logic        resp_valid;
    logic        misalign;
    logic        bus_err;
    logic [31:0] fault_addr;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .mem_valid(mem_valid), .memory_type(memory_type),
        .memory_rw(memory_rw), .addr(addr), .store_data(store_data), .mem_stall(mem_stall),
        .load_data(load_data), .resp_valid(resp_valid), .misalign(misalign), .bus_err(bus_err),
        .fault_addr(fault_addr), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    typedef struct {
        logic [3:0]  mt;
        logic [1:0]  rw;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          gnt_dly;
        bit          junk_rv;
        int          kind;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] load;
        int          stall;
    } vec_t;

    typedef struct {
        int          kind;
        bit          is_read;
        logic [31:0] load;
        logic [31:0] fault;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] mt, input logic [1:0] rw, input logic [31:0] a,
                                input logic [31:0] sd, input logic [31:0] rd, input int gd,
                                input bit junk, input int kind, input logic [3:0] be,
                                input logic [31:0] wd, input logic [31:0] ld, input int st);
        vec_t v;
        v.mt = mt; v.rw = rw; v.addr = a; v.sd = sd; v.rdata = rd; v.gnt_dly = gd;
        v.junk_rv = junk; v.kind = kind; v.be = be; v.wdata = wd; v.load = ld; v.stall = st;
        return v;
    endfunction

    // Drive one access, act as the bus slave, and score the terminating pulse.
    task automatic run_vec(input vec_t v, input int idx);
        exp_t        e;
        exp_t        got;
        int          stall_n = 0;
        int          req_n = 0;
        int          exp_req;
        bit          done = 0;
        bit          granted = 0;
        bit          unstable = 0;
        logic [31:0] exp_addr;
        string       tag;
        tag      = $sformatf("v%0d", idx);
        exp_addr = {v.addr[31:2], 2'b00};
        exp_req  = (v.kind == K_MIS) ? 0 : (v.kind == K_BUS) ? TO : v.gnt_dly + 1;
        e.kind = v.kind; e.is_read = (v.rw == M_R); e.load = v.load; e.fault = v.addr;
        sb.push_back(e);
        @(negedge clk);
        mem_valid = 1'b1; memory_type = v.mt; memory_rw = v.rw; addr = v.addr; store_data = v.sd;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            #1;
            if (mem_stall) stall_n++;
            if (resp_valid || misalign || bus_err) begin
                done = 1;
                mem_valid = 1'b0;
                got = sb.pop_front();
                check({tag, "_event"}, {29'd0, bus_err, misalign, resp_valid}, 32'd1 << got.kind);
                if (got.kind == K_RESP && got.is_read) check({tag, "_load"}, load_data, got.load);
                if (got.kind != K_RESP) check({tag, "_fault_addr"}, fault_addr, got.fault);
            end
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0BAD_F00D;
            if (dmem_req) begin
                if (req_n == 0) begin
                    check({tag, "_addr"}, dmem_addr, exp_addr);
                    check({tag, "_be_we"}, {27'd0, dmem_we, dmem_be}, {27'd0, v.rw == M_W, v.be});
                    check({tag, "_wdata"}, dmem_wdata, v.wdata);
                end else if (dmem_addr !== exp_addr || dmem_be !== v.be || dmem_wdata !== v.wdata) begin
                    unstable = 1;
                end
                if (req_n == v.gnt_dly) begin
                    dmem_gnt = 1'b1;
                    granted  = 1;
                end else if (v.junk_rv) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = 32'h5555_AAAA;
                end
                req_n++;
            end else if (granted && mem_stall) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = v.rdata;
            end
            if (!done) @(negedge clk);
        end
        if (!done) check({tag, "_completion_budget"}, 32'd0, 32'd1);
        check({tag, "_stall_cycles"}, stall_n, v.stall);
        check({tag, "_req_cycles"}, req_n, exp_req);
        if (exp_req > 1) check({tag, "_bus_stable"}, {31'd0, unstable}, 32'd0);
        @(negedge clk);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        #1;
        check({tag, "_back_idle"}, {27'd0, resp_valid, misalign, bus_err, mem_stall, dmem_req}, 32'd0);
    endtask

    // A request combination that must not start an access.
    task automatic run_noop(input string tag, input logic v, input logic [3:0] mt, input logic [1:0] rw);
        bit seen = 0;
        @(negedge clk);
        mem_valid = v; memory_type = mt; memory_rw = rw; addr = 32'h0000_0A00; store_data = 32'h1;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (mem_stall || dmem_req) seen = 1;
            @(negedge clk);
        end
        check({tag, "_no_activity"}, {31'd0, seen}, 32'd0);
        mem_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(MT_W,  M_R, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, K_RESP, 4'b1111, 32'h0,        32'hDEADBEEF, 3);
        vecs[1]  = mk(MT_B,  M_R, 32'h203, 32'h0,        32'h80FF1234, 0, 0, K_RESP, 4'b1000, 32'h0,        32'hFFFFFF80, 3);
        vecs[2]  = mk(MT_BU, M_R, 32'h203, 32'h0,        32'h80FF1234, 0, 0, K_RESP, 4'b1000, 32'h0,        32'h00000080, 3);
        vecs[3]  = mk(MT_HU, M_R, 32'h202, 32'h0,        32'h80FF1234, 0, 0, K_RESP, 4'b1100, 32'h0,        32'h000080FF, 3);
        vecs[4]  = mk(MT_B,  M_W, 32'h301, 32'h000000A5, 32'h0,        3, 0, K_RESP, 4'b0010, 32'hA5A5A5A5, 32'h0,        5);
        vecs[5]  = mk(MT_H,  M_W, 32'h602, 32'h1234BEEF, 32'h0,        1, 0, K_RESP, 4'b1100, 32'hBEEFBEEF, 32'h0,        3);
        vecs[6]  = mk(MT_H,  M_R, 32'h700, 32'h0,        32'h00008001, 2, 1, K_RESP, 4'b0011, 32'h0,        32'hFFFF8001, 5);
        vecs[7]  = mk(MT_W,  M_W, 32'h800, 32'h12345678, 32'h0,        0, 0, K_RESP, 4'b1111, 32'h12345678, 32'h0,        2);
        vecs[8]  = mk(MT_B,  M_R, 32'h001, 32'h0,        32'h00007F00, 0, 0, K_RESP, 4'b0010, 32'h0,        32'h0000007F, 3);
        vecs[9]  = mk(MT_H,  M_R, 32'h401, 32'h0,        32'h0,        0, 0, K_MIS,  4'b0000, 32'h0,        32'h0,        1);
        vecs[10] = mk(MT_W,  M_W, 32'h500, 32'hCAFEF00D, 32'h0,    NEVER, 0, K_BUS,  4'b1111, 32'hCAFEF00D, 32'h0,        5);
        vecs[11] = mk(MT_W,  M_R, 32'h902, 32'h0,        32'h0,        0, 0, K_MIS,  4'b0000, 32'h0,        32'h0,        1);

        reset_n = 1'b0; mem_valid = 1'b0; memory_type = MT_X; memory_rw = M_X;
        addr = 32'h0; store_data = 32'h0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_ctl", {25'd0, mem_stall, resp_valid, misalign, bus_err, dmem_req, dmem_we, dmem_be != 4'd0}, 32'd0);
        check("reset_load_data", load_data, 32'd0);
        check("reset_fault_addr", fault_addr, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        run_noop("noop_mx", 1'b1, MT_W, M_X);
        run_noop("noop_bubble", 1'b0, MT_W, M_R);
        run_noop("noop_mtx", 1'b1, MT_X, M_R);

        // Reset while a granted read waits for rvalid; the late rvalid must be ignored.
        @(negedge clk);
        mem_valid = 1'b1; memory_type = MT_W; memory_rw = M_R; addr = 32'h0000_0C00;
        #1;
        check("rst_wait_start_stall", {31'd0, mem_stall}, 32'd1);
        @(negedge clk);
        #1;
        check("rst_wait_req", {31'd0, dmem_req}, 32'd1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        #1;
        check("rst_wait_in_wait", {30'd0, mem_stall, dmem_req}, 32'd2);
        reset_n = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #1;
        check("rst_wait_ctl", {26'd0, mem_stall, resp_valid, misalign, bus_err, dmem_req, dmem_we}, 32'd0);
        check("rst_wait_bus", dmem_addr | dmem_wdata | {28'd0, dmem_be}, 32'd0);
        check("rst_wait_fault_addr", fault_addr, 32'd0);
        begin
            bit resp_seen = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                dmem_rvalid = 1'b0;
                #1;
                if (resp_valid || load_data !== 32'd0) resp_seen = 1;
            end
            check("rst_wait_no_resp", {31'd0, resp_seen}, 32'd0);
        end
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
